// File: rtl/nibble_scan_ctrl.sv
// Range scanner feeding the ex4_19 prime / div-by-3 classifier.
// Optional backpressure: define SCANNER_READY_EN to honour out_ready.
module nibble_scan_ctrl #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       lo,
  input  logic [3:0]       hi,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_a,
  output logic             out_p,
  output logic             out_d,
  output logic             done,
  output logic [CNT_W-1:0] prime_cnt,
  output logic [CNT_W-1:0] div3_cnt
);

  if (CNT_W < 5) begin : g_bad_cnt_w
    $error("nibble_scan_ctrl: CNT_W must be >= 5");
  end

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] cur;
  logic [3:0] hi_q;
  logic       p_raw;
  logic       d_raw;
  logic       xfer;

`ifdef SCANNER_READY_EN
  assign xfer = out_valid & out_ready;
`else
  logic unused_ready;
  assign unused_ready = out_ready;
  assign xfer = out_valid;
`endif

  always_comb begin
    p_raw = 1'b0;
    d_raw = 1'b0;
    case (cur)
      4'd2, 4'd3, 4'd5, 4'd7, 4'd11, 4'd13: p_raw = 1'b1;
      default: p_raw = 1'b0;
    endcase
    // zero is deliberately not flagged as divisible by three
    case (cur)
      4'd3, 4'd6, 4'd9, 4'd12, 4'd15: d_raw = 1'b1;
      default: d_raw = 1'b0;
    endcase
  end

  assign out_a = out_valid ? cur : 4'd0;
  assign out_p = out_valid & p_raw;
  assign out_d = out_valid & d_raw;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur       <= 4'd0;
      hi_q      <= 4'd0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      prime_cnt <= '0;
      div3_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            hi_q      <= hi;
            cur       <= lo;
            prime_cnt <= '0;
            div3_cnt  <= '0;
            busy      <= 1'b1;
            out_valid <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (xfer) begin
            prime_cnt <= prime_cnt + {{(CNT_W-1){1'b0}}, p_raw};
            div3_cnt  <= div3_cnt + {{(CNT_W-1){1'b0}}, d_raw};
            if (cur == hi_q) begin
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              cur <= cur + 4'd1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          out_valid <= 1'b0;
          done      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_scan_ctrl.sv
// Self-checking bench for nibble_scan_ctrl.
// Vector table, hand sequences and random scans against a range model.
module tb_nibble_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] lo = 4'd0;
  logic [3:0] hi = 4'd0;
  logic       out_ready = 1'b1;
  logic       busy, out_valid, out_p, out_d, done;
  logic [3:0] out_a;
  logic [4:0] prime_cnt, div3_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nibble_scan_ctrl #(.CNT_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .lo(lo), .hi(hi),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_p(out_p), .out_d(out_d), .done(done),
    .prime_cnt(prime_cnt), .div3_cnt(div3_cnt)
  );

  typedef struct {
    int lo;
    int hi;
    int ep;
    int ed;
    int mask;
    int mid;
  } vec_t;

  function automatic bit is_prime(int v);
    return v == 2 || v == 3 || v == 5 || v == 7 || v == 11 || v == 13;
  endfunction

  function automatic bit is_div3(int v);
    return v != 0 && (v % 3) == 0;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, " busy"}, int'(busy), 0);
    chk({nm, " valid"}, int'(out_valid), 0);
    chk({nm, " a"}, int'(out_a), 0);
    chk({nm, " p"}, int'(out_p), 0);
    chk({nm, " d"}, int'(out_d), 0);
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low on cycles in mask
  task automatic run_scan(input int l, input int h, input int ep,
                          input int ed, input int mode, input int mask,
                          input int mid);
    int q[$];
    int v, mp, md, idx, cyc;
    bit rdy;
    q.delete();
    v = l;
    forever begin
      q.push_back(v);
      if (v == h) break;
      v = (v + 1) % 16;
    end
    mp = 0;
    md = 0;
    foreach (q[i]) begin
      mp += int'(is_prime(q[i]));
      md += int'(is_div3(q[i]));
    end
    if (ep < 0) ep = mp;
    if (ed < 0) ed = md;
    chk("pre busy", int'(busy), 0);
    lo = 4'(l);
    hi = 4'(h);
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lo = 4'($urandom);
    hi = 4'($urandom);
    idx = 0;
    cyc = 0;
    while (idx < q.size() && cyc < 64) begin
      chk("beat valid", int'(out_valid), 1);
      chk("beat busy", int'(busy), 1);
      chk("beat done", int'(done), 0);
      chk("beat a", int'(out_a), q[idx]);
      chk("beat p", int'(out_p), int'(is_prime(q[idx])));
      chk("beat d", int'(out_d), int'(is_div3(q[idx])));
      if (cyc == mid) begin
        start = 1'b1;
        lo = 4'd12;
        hi = 4'd13;
      end else begin
        start = 1'b0;
      end
      case (mode)
        1: rdy = $urandom_range(0, 2) != 0;
        2: rdy = ((mask >> cyc) & 1) == 0;
        default: rdy = 1'b1;
      endcase
      out_ready = rdy;
`ifdef SCANNER_READY_EN
      if (rdy) idx++;
`else
      idx++;
`endif
      @(negedge clk);
      cyc++;
    end
    chk("scan timeout", int'(cyc < 64), 1);
    start = 1'b0;
    out_ready = 1'b1;
    chk("end done", int'(done), 1);
    chk("end valid", int'(out_valid), 0);
    chk("end busy", int'(busy), 1);
    chk("end prime_cnt", int'(prime_cnt), ep);
    chk("end div3_cnt", int'(div3_cnt), ed);
    @(negedge clk);
    chk("post done", int'(done), 0);
    chk_idle("post");
    chk("hold prime_cnt", int'(prime_cnt), ep);
    chk("hold div3_cnt", int'(div3_cnt), ed);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{0, 15, 6, 5, 0, -1});
    vecs.push_back('{6, 6, 0, 1, 0, -1});
    vecs.push_back('{13, 2, 2, 1, 0, -1});
    vecs.push_back('{2, 5, 3, 1, 32'b110, -1});
    vecs.push_back('{4, 9, 2, 2, 0, 2});
    vecs.push_back('{15, 14, 6, 5, 0, -1});
    vecs.push_back('{7, 7, 1, 0, 0, -1});

    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset done", int'(done), 0);
    chk("reset prime_cnt", int'(prime_cnt), 0);
    chk("reset div3_cnt", int'(div3_cnt), 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      run_scan(vecs[i].lo, vecs[i].hi, vecs[i].ep, vecs[i].ed,
               vecs[i].mask != 0 ? 2 : 0, vecs[i].mask, vecs[i].mid);

    // reset after the third beat of a full scan
    lo = 4'd0;
    hi = 4'd15;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid prime_cnt", int'(prime_cnt), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_idle("rst scan");
    chk("rst prime_cnt", int'(prime_cnt), 0);
    chk("rst div3_cnt", int'(div3_cnt), 0);
    begin
      int seen = 0;
      repeat (20) begin
        if (done || out_valid) seen++;
        @(negedge clk);
      end
      chk("rst no activity", seen, 0);
    end

    // start held high: scans restart one cycle after each done
    lo = 4'd1;
    hi = 4'd2;
    start = 1'b1;
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      chk("b2b a1 valid", int'(out_valid), 1);
      chk("b2b a1", int'(out_a), 1);
      chk("b2b a1 cnt", int'(prime_cnt), 0);
      @(negedge clk);
      chk("b2b a2", int'(out_a), 2);
      chk("b2b a2 p", int'(out_p), 1);
      @(negedge clk);
      chk("b2b done", int'(done), 1);
      chk("b2b prime_cnt", int'(prime_cnt), 1);
      chk("b2b div3_cnt", int'(div3_cnt), 0);
      @(negedge clk);
      chk("b2b gap busy", int'(busy), 0);
      chk("b2b gap done", int'(done), 0);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk_idle("b2b end");

    for (int k = 0; k < 25; k++)
      run_scan($urandom_range(0, 15), $urandom_range(0, 15), -1, -1,
               1, 0, (k % 4 == 0) ? 1 : -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
